// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, multi-cycle results
// queue in a small FIFO, drain into idle WB slots, and are killed on a younger WB write.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_we,
    input  logic [4:0]    p_rd,
    input  logic [DW-1:0] p_wd,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [4:0]    m_rd,
    input  logic [DW-1:0] m_wd,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    output logic          rs_pending,
    output logic          rt_pending,
    output logic          stall_req,
    output logic          rf_we,
    output logic [4:0]    rf_rd,
    output logic [DW-1:0] rf_wd
);
    localparam int unsigned RW    = 5;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic          kill;
        logic [RW-1:0] rd;
        logic [DW-1:0] wd;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_e;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    state_e           state_q, state_d;
    logic             stall_req_q, stall_req_d;
    logic             rf_we_q, rf_we_d;
    logic [RW-1:0]    rf_rd_q, rf_rd_d;
    logic [DW-1:0]    rf_wd_q, rf_wd_d;

    logic   wb_eff;
    logic   empty;
    logic   full;
    logic   push;
    entry_t head;
    logic   rs_hit;
    logic   rt_hit;

    // Entries are contiguous from rd_ptr, so the slot under wr_ptr is occupied only when full.
    assign wb_eff  = p_we && (p_rd != '0);
    assign empty   = ~|valid_q;
    assign full    = valid_q[wr_ptr_q];
    assign push    = m_valid && !full && (m_rd != '0);
    assign head    = fifo_q[rd_ptr_q];
    assign m_ready = !full;

    // Write-port selection, WAW kill, FIFO push/pop and starvation count.
    always_comb begin
        fifo_d   = fifo_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rf_we_d  = 1'b0;
        rf_rd_d  = rf_rd_q;
        rf_wd_d  = rf_wd_q;
        starve_d = '0;

        if (wb_eff) begin
            rf_we_d = 1'b1;
            rf_rd_d = p_rd;
            rf_wd_d = p_wd;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[PTR_W'(i)] && (fifo_q[PTR_W'(i)].rd == p_rd)) begin
                    fifo_d[PTR_W'(i)].kill = 1'b1;
                end
            end
            if (!empty) begin
                starve_d = (starve_q < CNT_W'(STARVE_LIMIT)) ? starve_q + CNT_W'(1) : starve_q;
            end
        end else if (!empty) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            if (!head.kill) begin
                rf_we_d = 1'b1;
                rf_rd_d = head.rd;
                rf_wd_d = head.wd;
            end
        end

        // The incoming entry lands after the kill scan, so a same-cycle WB write never kills it.
        if (push) begin
            fifo_d[wr_ptr_q]  = '{kill: 1'b0, rd: m_rd, wd: m_wd};
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    // Drain-pressure FSM: stall the pipeline once the queue has been starved long enough.
    always_comb begin
        state_d     = state_q;
        stall_req_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (empty) begin
                    state_d = S_IDLE;
                end else if (starve_q >= CNT_W'(STARVE_LIMIT)) begin
                    state_d = S_FORCE;
                end
            end
            S_FORCE: begin
                if (empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        stall_req_d = (state_d == S_FORCE);
    end

    // Hazard lookup against live, unkilled queue entries and the write leaving this cycle.
    always_comb begin
        rs_hit = rf_we_q && (rf_rd_q == rs);
        rt_hit = rf_we_q && (rf_rd_q == rt);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PTR_W'(i)] && !fifo_q[PTR_W'(i)].kill) begin
                if (fifo_q[PTR_W'(i)].rd == rs) rs_hit = 1'b1;
                if (fifo_q[PTR_W'(i)].rd == rt) rt_hit = 1'b1;
            end
        end
    end

    assign rs_pending = rs_hit && (rs != '0);
    assign rt_pending = rt_hit && (rt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q      <= '{default: '0};
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            starve_q    <= '0;
            state_q     <= S_IDLE;
            stall_req_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wd_q     <= '0;
        end else begin
            fifo_q      <= fifo_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            starve_q    <= starve_d;
            state_q     <= state_d;
            stall_req_q <= stall_req_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wd_q     <= rf_wd_d;
        end
    end

    assign stall_req = stall_req_q;
    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wd     = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle vector table, then scoreboarded multi-cycle sequences
// (starvation/force, WAW kill, full FIFO, reset while forcing).
module tb_rf_wb_arbiter;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_we;
    logic [4:0]    p_rd;
    logic [DW-1:0] p_wd;
    logic          m_valid;
    logic          m_ready;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_wd;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rs_pending;
    logic          rt_pending;
    logic          stall_req;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wd;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_we       (p_we),
        .p_rd       (p_rd),
        .p_wd       (p_wd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_rd       (m_rd),
        .m_wd       (m_wd),
        .rs         (rs),
        .rt         (rt),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .stall_req  (stall_req),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd)
    );

    typedef struct {
        logic        p_we;
        logic [4:0]  p_rd;
        logic [31:0] p_wd;
        logic        m_valid;
        logic [4:0]  m_rd;
        logic [31:0] m_wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_rsp;
        logic        e_rtp;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        sb_on   = 1'b0;
    logic [36:0] exp_q [$];
    logic [36:0] sb_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one cycle of inputs; every effective WB write is expected on rf_* next cycle.
    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
        p_we    = we;
        p_rd    = rd;
        p_wd    = wd;
        m_valid = mv;
        m_rd    = mrd;
        m_wd    = mwd;
        if (sb_on && we && (rd != 5'd0)) exp_q.push_back({rd, wd});
    endtask

    function automatic vec_t mk(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                                input logic [4:0] vrs, input logic [4:0] vrt,
                                input logic ewe, input logic [4:0] erd, input logic [31:0] ewd,
                                input logic ersp, input logic ertp, input logic erdy,
                                input logic estall);
        vec_t v;
        v.p_we = pwe;  v.p_rd = prd;  v.p_wd = pwd;
        v.m_valid = mv; v.m_rd = mrd; v.m_wd = mwd;
        v.rs = vrs;    v.rt = vrt;
        v.e_we = ewe;  v.e_rd = erd;  v.e_wd = ewd;
        v.e_rsp = ersp; v.e_rtp = ertp; v.e_rdy = erdy; v.e_stall = estall;
        return v;
    endfunction

    // Scoreboard: every rf write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sb_on && rf_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got rd=%0d wd=0x%0h, expected no write", rf_rd, rf_wd);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_write", 64'({rf_rd, rf_wd}), 64'(sb_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   c;
        int   nw;
        logic seen;

        vecs[0]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  32'hA5A5_0001, 5'd5,  5'd6,  1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  1'b1, 5'd5,  32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  1'b0, 5'd5,  32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 5'd0,  32'hDEAD_BEEF, 1'b1, 5'd0,  32'h1111_1111, 5'd0,  5'd5,  1'b0, 5'd5,  32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd5,  32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 5'd3,  32'h3333_3333, 1'b1, 5'd3,  32'h4444_4444, 5'd3,  5'd4,  1'b1, 5'd3,  32'h3333_3333, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd3,  5'd4,  1'b1, 5'd3,  32'h4444_4444, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd3,  5'd4,  1'b0, 5'd3,  32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 5'd10, 32'h0000_000A, 1'b1, 5'd11, 32'h0000_000B, 5'd11, 5'd10, 1'b1, 5'd10, 32'h0000_000A, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 5'd12, 32'h0000_000C, 1'b1, 5'd13, 32'h0000_000D, 5'd11, 5'd13, 1'b1, 5'd12, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd12, 5'd13, 1'b1, 5'd11, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd11, 5'd13, 1'b1, 5'd13, 32'h0000_000D, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd13, 5'd0,  1'b0, 5'd13, 32'h0000_000D, 1'b0, 1'b0, 1'b1, 1'b0);

        rst = 1'b1;
        rs  = 5'd5;
        rt  = 5'd5;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        check("reset_state", 64'({rf_we, rf_rd, rf_wd, stall_req, m_ready, rs_pending, rt_pending}),
              64'({1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].p_we, vecs[i].p_rd, vecs[i].p_wd, vecs[i].m_valid, vecs[i].m_rd, vecs[i].m_wd);
            rs = vecs[i].rs;
            rt = vecs[i].rt;
            step();
            check($sformatf("vec%0d", i),
                  64'({rf_we, rf_rd, rf_wd, rs_pending, rt_pending, m_ready, stall_req}),
                  64'({vecs[i].e_we, vecs[i].e_rd, vecs[i].e_wd, vecs[i].e_rsp, vecs[i].e_rtp,
                       vecs[i].e_rdy, vecs[i].e_stall}));
        end

        sb_on = 1'b1;

        // Starvation: rd=7 queued behind continuous WB writes until stall_req rises.
        rs   = 5'd7;
        rt   = 5'd0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            drive(1'b1, 5'd3, 32'h3000_0000 + 32'(c), c == 0, 5'd7, 32'h7777_7777);
            step();
            if (c == 0) check("starve_rs_pending", 64'(rs_pending), 64'd1);
            seen = stall_req;
            c++;
        end
        check("starve_rise_cycle", 64'(c), 64'd10);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_q.push_back({5'd7, 32'h7777_7777});
        step();
        check("force_drain_we", 64'({rf_we, stall_req}), 64'({1'b1, 1'b1}));
        step();
        check("force_stall_drop", 64'({rf_we, stall_req}), 64'({1'b0, 1'b0}));

        // WAW kill: queued rd=9/wd=1 is overtaken by WB rd=9/wd=2 and must never be written.
        rs = 5'd9;
        drive(1'b1, 5'd3, 32'h3000_00B0, 1'b1, 5'd9, 32'h0000_0001);
        step();
        check("kill_pend_queued", 64'(rs_pending), 64'd1);
        drive(1'b1, 5'd9, 32'h0000_0002, 1'b0, 5'd0, 32'h0);
        step();
        check("kill_pend_wb", 64'({rs_pending, rf_we, rf_rd}), 64'({1'b1, 1'b1, 5'd9}));
        drive(1'b1, 5'd3, 32'h3000_00B1, 1'b0, 5'd0, 32'h0);
        step();
        check("kill_pend_clear", 64'(rs_pending), 64'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("kill_dropped", 64'(rf_we), 64'd0);
        step();
        check("kill_idle", 64'({rf_we, stall_req}), 64'd0);

        // Full FIFO: four entries fill it; the fifth waits for a pop; rd=0 is swallowed.
        rs = 5'd0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h3000_0C00 + 32'(i), 1'b1, 5'(20 + i), 32'h2000_0000 + 32'(i));
            step();
        end
        check("full_not_ready", 64'(m_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 32'h3000_0D00 + 32'(i), 1'b1, 5'd24, 32'h2000_0004);
            step();
            check($sformatf("full_held%0d", i), 64'(m_ready), 64'd0);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back({5'(20 + i), 32'h2000_0000 + 32'(i)});
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'h2000_0004);
        step();
        check("full_ready_after_pop", 64'(m_ready), 64'd1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (4) step();
        check("full_drained", 64'({rf_we, m_ready, stall_req}), 64'({1'b0, 1'b1, 1'b0}));

        // Reset while forcing with three queued entries discards them all.
        rs   = 5'd14;
        rt   = 5'd15;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            drive(1'b1, 5'd3, 32'h3000_0E00 + 32'(c), c < 3, 5'(14 + c), 32'h1400_0000 + 32'(c));
            step();
            seen = stall_req;
            c++;
        end
        check("rst_force_reached", 64'({seen, rs_pending, rt_pending}), 64'({1'b1, 1'b1, 1'b1}));
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        check("rst_in_force", 64'({rf_we, rf_rd, rf_wd, stall_req, m_ready, rs_pending, rt_pending}),
              64'({1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
        rst = 1'b0;
        nw  = 0;
        repeat (6) begin
            step();
            if (rf_we) nw++;
        end
        check("rst_no_write_after", 64'(nw), 64'd0);
        check("rst_quiet", 64'({stall_req, rs_pending, m_ready}), 64'({1'b0, 1'b0, 1'b1}));

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
